hack_boot_ctrl: RTL and testbench

Boot and run controller for the HACK CPU.
- Holds the CPU in reset while a program image streams in over a valid/ready word interface.
- Writes each word into instruction ROM at consecutive addresses from 0.
- Releases the CPU once the image is loaded, then returns it to reset when the PC runs past the end of the program or software requests a stop.
- Sits between the host/loader link, the instruction ROM write port and the CPU reset input.

---
 rtl/hack_boot_ctrl_if.sv | 10 +
 rtl/hack_boot_ctrl.sv | 155 +++++++++++++++
 tb/tb_hack_boot_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_boot_ctrl_if.sv
// Word stream from the host/loader link into the boot controller.
// The loader drives data/valid; the controller answers with ready.
interface hack_boot_ctrl_if;
  logic [15:0] data;
  logic        valid;
  logic        ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/hack_boot_ctrl.sv
// Boot/run controller for the HACK CPU: streams an image into instruction ROM
// with the CPU held in reset, then runs it until the PC leaves the image or a stop.
//
// state | meaning
// IDLE  | no valid image, or last load_start rejected; CPU in reset
// LOAD  | accepting image words, one ROM write per accepted word; CPU in reset
// RUN   | CPU released; run_cycles counting
// DONE  | program finished or stopped; CPU in reset, image still loaded
module hack_boot_ctrl #(
  parameter int ROM_AW    = 15,
  parameter int ROM_WORDS = 32768
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start_i,
  input  logic [15:0]       load_len_i,
  input  logic              run_start_i,
  input  logic              stop_i,
  hack_boot_ctrl_if.slave   s_if,
  output logic              rom_we_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  output logic [15:0]       rom_wdata_o,
  input  logic [15:0]       pc_i,
  output logic              cpu_reset_o,
  output logic [1:0]        state_o,
  output logic [15:0]       words_loaded_o,
  output logic [15:0]       run_cycles_o,
  output logic              error_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [16:0] MAX_LEN = 17'(ROM_WORDS);

  logic [1:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       words_q, words_d;
  logic [15:0]       run_q, run_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;

  logic              len_ok;
  logic              xfer;
  logic [15:0]       words_inc;
  logic [15:0]       run_sat;

  assign len_ok    = (load_len_i != 16'd0) && ({1'b0, load_len_i} <= MAX_LEN);
  assign xfer      = (state_q == S_LOAD) && ready_q && s_if.valid;
  assign words_inc = words_q + 16'd1;
  assign run_sat   = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    words_d = words_q;
    run_d   = run_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (state_q == S_RUN) begin
      run_d = run_sat;
    end

    // load_start outranks every other event in every state
    if (load_start_i) begin
      if (len_ok) begin
        state_d = S_LOAD;
        len_d   = load_len_i;
        words_d = 16'd0;
        err_d   = 1'b0;
      end else begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_start_i && (len_q != 16'd0)) begin
            state_d = S_RUN;
            run_d   = 16'd0;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            we_d    = 1'b1;
            addr_d  = words_q[ROM_AW-1:0];
            wdata_d = s_if.data;
            words_d = words_inc;
            if (words_inc == len_q) begin
              state_d = S_RUN;
              run_d   = 16'd0;
            end
          end
        end
        S_RUN: begin
          if (stop_i || (pc_i >= len_q)) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (run_start_i) begin
            state_d = S_RUN;
            run_d   = 16'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    ready_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= 16'd0;
      words_q <= 16'd0;
      run_q   <= 16'd0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      words_q <= words_d;
      run_q   <= run_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign s_if.ready     = ready_q;
  assign rom_we_o       = we_q;
  assign rom_addr_o     = addr_q;
  assign rom_wdata_o    = wdata_q;
  assign cpu_reset_o    = (state_q != S_RUN);
  assign state_o        = state_q;
  assign words_loaded_o = words_q;
  assign run_cycles_o   = run_q;
  assign error_o        = err_q;

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// Randomized self-checking bench for hack_boot_ctrl against a transaction-level
// model (image queue, word counts, saturating cycle arithmetic).
module tb_hack_boot_ctrl;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic [15:0]   load_len = 16'd0;
  logic          run_start = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   pc_in = 16'd0;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_wdata;
  logic          cpu_reset;
  logic [1:0]    state;
  logic [15:0]   words_loaded;
  logic [15:0]   run_cycles;
  logic          error;

  hack_boot_ctrl_if bus ();

  hack_boot_ctrl #(.ROM_AW(AW), .ROM_WORDS(32768)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_start_i   (load_start),
    .load_len_i     (load_len),
    .run_start_i    (run_start),
    .stop_i         (stop),
    .s_if           (bus.slave),
    .rom_we_o       (rom_we),
    .rom_addr_o     (rom_addr),
    .rom_wdata_o    (rom_wdata),
    .pc_i           (pc_in),
    .cpu_reset_o    (cpu_reset),
    .state_o        (state),
    .words_loaded_o (words_loaded),
    .run_cycles_o   (run_cycles),
    .error_o        (error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model: 0 IDLE, 1 LOAD, 2 RUN, 3 DONE
  int m_state = 0;
  int m_len   = 0;
  int m_words = 0;
  int m_runc  = 0;
  int m_err   = 0;
  logic [15:0] img[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".state"}, 32'(state), m_state);
    chk({tag, ".cpu_reset"}, 32'(cpu_reset), (m_state != 2) ? 1 : 0);
    chk({tag, ".s_ready"}, 32'(bus.ready), (m_state == 1) ? 1 : 0);
    chk({tag, ".error"}, 32'(error), m_err);
    chk({tag, ".words"}, 32'(words_loaded), m_words);
    chk({tag, ".run_cycles"}, 32'(run_cycles), m_runc);
  endtask

  task automatic fill_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(16'($urandom));
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random valid
  task automatic do_load(input int n, input int mode, input int stop_after, input bit with_stop);
    int idx;
    int cyc;
    bit v;
    load_start = 1'b1;
    load_len   = 16'(n);
    stop       = with_stop;
    tick();
    load_start = 1'b0;
    stop       = 1'b0;
    if (m_state == 2) m_runc = sat16(m_runc + 1);
    m_state = 1; m_len = n; m_words = 0; m_err = 0;
    check_status("ld_start");
    idx = 0;
    cyc = 0;
    while (idx < stop_after) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 1);
        default: v = (cyc > 4 * n) ? 1'b1 : 1'($urandom_range(1, 0));
      endcase
      bus.valid = v;
      bus.data  = v ? img[idx] : 16'($urandom);
      tick();
      bus.valid = 1'b0;
      chk("ld.we", 32'(rom_we), 32'(v));
      if (v) begin
        chk("ld.addr", 32'(rom_addr), idx);
        chk("ld.data", 32'(rom_wdata), 32'(img[idx]));
        idx++;
        m_words = idx;
        if (idx == n) begin
          m_state = 2;
          m_runc  = 0;
        end
      end
      check_status("ld");
      cyc++;
    end
  endtask

  // k cycles with pc inside the image, then end by 0: pc==len, 1: pc>len, 2: stop
  task automatic do_run(input int k, input int end_mode);
    for (int i = 0; i < k; i++) begin
      pc_in = 16'($urandom_range(m_len - 1, 0));
      tick();
      m_runc = sat16(m_runc + 1);
      if (i == 0) chk("run.we", 32'(rom_we), 0);
      if (k <= 1000 || i < 4) check_status("run");
    end
    case (end_mode)
      0:       pc_in = 16'(m_len);
      1:       pc_in = 16'($urandom_range(65535, m_len));
      default: begin
        stop  = 1'b1;
        pc_in = 16'($urandom_range(m_len - 1, 0));
      end
    endcase
    tick();
    stop   = 1'b0;
    pc_in  = 16'd0;
    m_runc = sat16(m_runc + 1);
    m_state = 3;
    check_status("run_end");
  endtask

  task automatic do_run_start();
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    if ((m_state == 0 || m_state == 3) && m_len != 0) begin
      m_state = 2;
      m_runc  = 0;
    end
    check_status("run_start");
    chk("run_start.we", 32'(rom_we), 0);
  endtask

  task automatic do_bad_load(input int len);
    load_start = 1'b1;
    load_len   = 16'(len);
    tick();
    load_start = 1'b0;
    if (m_state == 2) m_runc = sat16(m_runc + 1);
    m_state = 0;
    m_err   = 1;
    check_status("bad_load");
    chk("bad_load.we", 32'(rom_we), 0);
    tick();
    check_status("bad_idle");
    chk("bad_idle.we", 32'(rom_we), 0);
  endtask

  initial begin
    bus.valid = 1'b0;
    bus.data  = 16'd0;

    #12;
    check_status("reset");
    chk("reset.we", 32'(rom_we), 0);
    chk("reset.addr", 32'(rom_addr), 0);
    chk("reset.wdata", 32'(rom_wdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // rejected lengths, then run_start with nothing loaded
    do_bad_load(0);
    do_bad_load(40000);
    do_run_start();

    // fixed image, back-to-back, then pc walks 0..4
    img.delete();
    img.push_back(16'h000B); img.push_back(16'hEC10);
    img.push_back(16'h0010); img.push_back(16'hE348);
    do_load(4, 0, 4, 1'b0);
    for (int p = 0; p < 4; p++) begin
      pc_in = 16'(p);
      tick();
      m_runc = sat16(m_runc + 1);
      check_status("walk");
    end
    pc_in = 16'd4;
    tick();
    pc_in = 16'd0;
    m_runc = sat16(m_runc + 1);
    m_state = 3;
    check_status("walk_end");
    chk("walk_end.run_cycles5", 32'(run_cycles), 5);

    // same image with valid toggling
    do_load(4, 1, 4, 1'b0);
    chk("toggle.words", 32'(words_loaded), 4);
    do_run(3, 0);

    // long run saturates the cycle counter
    do_run_start();
    do_run(70000, 2);
    chk("sat.run_cycles", 32'(run_cycles), 32'hFFFF);

    // abort a running program with load_start + stop together
    do_run_start();
    fill_img(2);
    do_load(2, 0, 2, 1'b1);
    do_run(2, 2);
    do_run_start();
    do_run(1, 0);

    // reset mid-load after 2 of 4 words
    fill_img(4);
    do_load(4, 0, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    m_state = 0; m_len = 0; m_words = 0; m_runc = 0; m_err = 0;
    check_status("mid_reset");
    chk("mid_reset.we", 32'(rom_we), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_run_start();

    // randomized loads and runs
    for (int it = 0; it < 25; it++) begin
      int n;
      int sel;
      n = $urandom_range(24, 1);
      fill_img(n);
      do_load(n, 2, n, 1'b0);
      do_run($urandom_range(30, 0), $urandom_range(2, 0));
      sel = $urandom_range(2, 0);
      if (sel == 0) begin
        do_run_start();
        do_run($urandom_range(10, 0), $urandom_range(2, 0));
      end else if (sel == 1) begin
        do_bad_load(($urandom_range(1, 0) == 0) ? 0 : $urandom_range(65535, 32769));
        do_run_start();
        do_run($urandom_range(10, 0), $urandom_range(2, 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
